// File: rtl/fprint_vote_comparator.sv
// fprint_vote_comparator: N-way fingerprint comparator and majority voter.
// Each core writes 32-bit fingerprints as two halves. Each core has a private
// FIFO. The heads of all enabled FIFOs are compared together. Mismatches and
// verified task completions are reported over the status_write/status_ack
// handshake.
// Optional build macro FPRINT_VOTE_TIMEOUT_EN adds a watchdog. It flushes the
// enabled FIFOs and reports a timeout when some enabled cores stall.
module fprint_vote_comparator #(
    parameter int NUM_CORES      = 3,
    parameter int CORE_IDX_W     = 2,
    parameter int CRC_WIDTH      = 32,
    parameter int TASK_W         = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fprint_write,
    input  logic [CORE_IDX_W-1:0] fprint_core,
    input  logic [31:0]           fprint_writedata,
    output logic                  fprint_waitrequest,
    input  logic [NUM_CORES-1:0]  core_enable,
    output logic                  status_write,
    input  logic                  status_ack,
    output logic [TASK_W-1:0]     status_task,
    output logic                  status_mismatch,
    output logic [NUM_CORES-1:0]  status_faulty,
    output logic                  status_timeout,
    output logic                  protocol_error
);
    localparam int HALF_W  = CRC_WIDTH / 2;
    localparam int ENTRY_W = TASK_W + 1 + CRC_WIDTH;   // {task, last, fprint}
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_REPORT} state_t;
    state_t state_q, state_d;

    // Write bus fields
    logic              wr_upper, wr_last;
    logic [TASK_W-1:0] wr_task;
    logic [HALF_W-1:0] wr_half;
    logic              unused_wdata;
    assign wr_upper     = fprint_writedata[5];
    assign wr_last      = fprint_writedata[6];
    assign wr_task      = fprint_writedata[TASK_W-1:0];
    assign wr_half      = fprint_writedata[31 -: HALF_W];
    assign unused_wdata = ^{fprint_writedata[15:7], fprint_writedata[4]};

    // Per-core state
    logic [NUM_CORES-1:0] en_q, stg_valid, full, empty, accept, push, pop, flush, perr_v;
    logic [HALF_W-1:0]    stg_half [NUM_CORES];
    logic [TASK_W-1:0]    stg_task [NUM_CORES];
    logic [PW-1:0]        wr_ptr   [NUM_CORES];
    logic [PW-1:0]        rd_ptr   [NUM_CORES];
    logic [PW-1:0]        fill     [NUM_CORES];
    logic [ENTRY_W-1:0]   mem      [NUM_CORES][FIFO_DEPTH];
    logic [ENTRY_W-1:0]   head     [NUM_CORES];
    logic                 tmo_fire;

    // Steer the write to its core, stall a full upper write, flag malformed halves
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        fprint_waitrequest = 1'b0;
        full   = '0;
        empty  = '0;
        accept = '0;
        push   = '0;
        perr_v = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            fill[i]  = wr_ptr[i] - rd_ptr[i];
            head[i]  = mem[i][rd_ptr[i][AW-1:0]];
            full[i]  = (fill[i] == PW'(FIFO_DEPTH));
            empty[i] = (fill[i] == '0);
            if (fprint_write && fprint_core == CORE_IDX_W'(i)) begin
                if (wr_upper && full[i]) fprint_waitrequest = 1'b1;
                else                     accept[i] = 1'b1;
            end
            push[i]   = accept[i] && en_q[i] && wr_upper && stg_valid[i] && (stg_task[i] == wr_task);
            perr_v[i] = accept[i] && en_q[i] && wr_upper && !(stg_valid[i] && (stg_task[i] == wr_task));
        end
        flush = ~en_q | (tmo_fire ? en_q : '0);
    end

    // Enable mask is frozen while a report is outstanding
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset)                 en_q <= '0;
        else if (state_q != S_REPORT) en_q <= core_enable;
    end

    // Staging-valid flags and FIFO pointers; flushing keeps any same-cycle push out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_valid      <= '0;
            protocol_error <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            protocol_error <= |perr_v;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!en_q[i])       stg_valid[i] <= 1'b0;
                else if (accept[i]) stg_valid[i] <= !wr_upper;
                wr_ptr[i] <= wr_ptr[i] + PW'(push[i]);
                if (flush[i]) rd_ptr[i] <= wr_ptr[i] + PW'(push[i]);
                else          rd_ptr[i] <= rd_ptr[i] + PW'(pop[i]);
            end
        end
    end

    // Staged lower halves and FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: data storage has no reset; valid flags and pointers alone say what is live.
        for (int i = 0; i < NUM_CORES; i++) begin
            if (accept[i] && !wr_upper) begin
                stg_half[i] <= wr_half;
                stg_task[i] <= wr_task;
            end
            if (push[i]) mem[i][wr_ptr[i][AW-1:0]] <= {wr_task, wr_last, wr_half, stg_half[i]};
        end
    end

    // Majority vote across enabled heads, plus timeout fault attribution
    int                   en_cnt, agree_cnt;
    logic                 maj_found, vote_report;
    logic [ENTRY_W-1:0]   maj_entry;
    logic [NUM_CORES-1:0] agree, vote_faulty, tmo_faulty;
    logic [TASK_W-1:0]    low_task, vote_task, tmo_task;
    always_comb begin
        en_cnt    = 0;
        agree_cnt = 0;
        maj_found = 1'b0;
        maj_entry = '0;
        agree     = '0;
        low_task  = '0;
        tmo_task  = '0;
        for (int i = 0; i < NUM_CORES; i++) en_cnt += int'(en_q[i]);
        for (int i = 0; i < NUM_CORES; i++) begin
            agree_cnt = 0;
            for (int j = 0; j < NUM_CORES; j++)
                if (en_q[j] && head[j] == head[i]) agree_cnt++;
            if (en_q[i] && !maj_found && 2 * agree_cnt > en_cnt) begin
                maj_found = 1'b1;
                maj_entry = head[i];
            end
        end
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            agree[j] = en_q[j] && (head[j] == maj_entry);
            if (en_q[j])              low_task = head[j][ENTRY_W-1 -: TASK_W];
            if (en_q[j] && !empty[j]) tmo_task = head[j][ENTRY_W-1 -: TASK_W];
        end
        vote_faulty = maj_found ? (en_q & ~agree) : en_q;
        vote_task   = maj_found ? maj_entry[ENTRY_W-1 -: TASK_W] : low_task;
        vote_report = (|vote_faulty) || (maj_found && maj_entry[CRC_WIDTH]);
        tmo_faulty  = en_q & empty;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and pops
    always_comb begin
        state_d = state_q;
        pop     = '0;
        case (state_q)
            S_IDLE: begin
                if (tmo_fire)                                     state_d = S_REPORT;
                else if (en_cnt >= 2 && ((en_q & ~empty) == en_q)) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                pop     = en_q & ~empty;
                state_d = vote_report ? S_REPORT : S_IDLE;
            end
            S_REPORT: if (status_ack) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign status_write = (state_q == S_REPORT);

    // Latch report contents when entering REPORT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_task     <= '0;
            status_mismatch <= 1'b0;
            status_faulty   <= '0;
        end else if (state_q == S_COMPARE && vote_report) begin
            status_task     <= vote_task;
            status_mismatch <= |vote_faulty;
            status_faulty   <= vote_faulty;
        end else if (tmo_fire) begin
            status_task     <= tmo_task;
            status_mismatch <= 1'b1;
            status_faulty   <= tmo_faulty;
        end
    end

`ifdef FPRINT_VOTE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_cond;
    assign tmo_cond = (state_q == S_IDLE) && |(en_q & ~empty) && |(en_q & empty);
    assign tmo_fire = tmo_cond && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts while some enabled cores have data and others do not
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   tmo_cnt <= '0;
        else if (!tmo_cond || tmo_fire) tmo_cnt <= '0;
        else                          tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Timeout flag follows the kind of report being latched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                       status_timeout <= 1'b0;
        else if (state_q == S_COMPARE && vote_report)     status_timeout <= 1'b0;
        else if (tmo_fire)                                status_timeout <= 1'b1;
    end
`else
    logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] unused_tmo_cnt;
    assign unused_tmo_cnt = '0;
    assign tmo_fire       = 1'b0;
    assign status_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fprint_vote_comparator.sv
// Directed bench for fprint_vote_comparator. Expected reports are queued as
// stimulus is driven and are popped when status_write rises.
module tb_fprint_vote_comparator;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fprint_write = 1'b0;
    logic [1:0]  fprint_core = '0;
    logic [31:0] fprint_writedata = '0;
    logic [2:0]  core_enable = '0;
    logic        status_ack = 1'b0;
    logic        fprint_waitrequest, status_write, status_mismatch, status_timeout, protocol_error;
    logic [3:0]  status_task;
    logic [2:0]  status_faulty;

    fprint_vote_comparator #(
        .NUM_CORES(3), .CORE_IDX_W(2), .CRC_WIDTH(32), .TASK_W(4),
        .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset),
        .fprint_write(fprint_write), .fprint_core(fprint_core),
        .fprint_writedata(fprint_writedata), .fprint_waitrequest(fprint_waitrequest),
        .core_enable(core_enable),
        .status_write(status_write), .status_ack(status_ack),
        .status_task(status_task), .status_mismatch(status_mismatch),
        .status_faulty(status_faulty), .status_timeout(status_timeout),
        .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] tk;
        logic       mm;
        logic [2:0] fl;
        logic       tmo;
    } rpt_t;

    rpt_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] tk, input logic mm, input logic [2:0] fl, input logic tmo);
        rpt_t e;
        e.tk = tk; e.mm = mm; e.fl = fl; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    task automatic drive_half(input int c, input logic upper, input logic last,
                              input logic [3:0] tk, input logic [15:0] d);
        @(negedge clk);
        fprint_write     = 1'b1;
        fprint_core      = 2'(c);
        fprint_writedata = {d, 9'b0, last, upper, 1'b0, tk};
    endtask

    task automatic bus_idle();
        @(negedge clk);
        fprint_write = 1'b0;
    endtask

    task automatic write_fp(input int c, input logic [3:0] tk, input logic last, input logic [31:0] v);
        drive_half(c, 1'b0, 1'b0, tk, v[15:0]);
        drive_half(c, 1'b1, last, tk, v[31:16]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; fprint_write = 1'b0; status_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_write(input int budget, output int n);
        n = 0;
        while (status_write !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Wait for a report, score it against the queue head, then acknowledge it
    task automatic wait_report(input int budget, output int lat);
        rpt_t e;
        wait_write(budget, lat);
        check("report_seen", status_write, 1'b1);
        if (status_write === 1'b1) begin
            check("report_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("status_task", status_task, e.tk);
                check("status_mismatch", status_mismatch, e.mm);
                check("status_faulty", status_faulty, e.fl);
                check("status_timeout", status_timeout, e.tmo);
            end
            status_ack = 1'b1;
            @(negedge clk);
            status_ack = 1'b0;
            check("ack_drop", status_write, 1'b0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int lat;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_status_write", status_write, 1'b0);
        check("rst_waitrequest", fprint_waitrequest, 1'b0);
        check("rst_protocol_error", protocol_error, 1'b0);
        check("rst_outputs", {status_task, status_mismatch, status_faulty, status_timeout}, '0);
        reset = 1'b1;

        // Three agreeing cores; only the last-of-task entry reports
        core_enable = 3'b111;
        bus_idle(); bus_idle();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 3; c++) write_fp(c, 4'd2, 1'b0, 32'hDEADBEEF + 32'(k));
        bus_idle();
        repeat (3) @(negedge clk);
        check("no_early_report", status_write, 1'b0);
        push_exp(4'd2, 1'b0, 3'b000, 1'b0);
        for (int c = 0; c < 3; c++) write_fp(c, 4'd2, 1'b1, 32'hDEADBEF1);
        bus_idle();
        wait_report(10, lat);
        check("report_latency", lat, 2);

        // Core 1 outvoted; the next entries (written during REPORT) agree
        push_exp(4'd0, 1'b1, 3'b010, 1'b0);
        push_exp(4'd0, 1'b0, 3'b000, 1'b0);
        write_fp(0, 4'd0, 1'b0, 32'hDEADBEEF);
        write_fp(1, 4'd0, 1'b0, 32'hDEADBEF0);
        write_fp(2, 4'd0, 1'b0, 32'hDEADBEEF);
        for (int c = 0; c < 3; c++) write_fp(c, 4'd0, 1'b1, 32'h00000001);
        bus_idle();
        wait_report(10, lat);
        wait_report(10, lat);

        // Two cores disagree: no majority; core 2 writes are discarded
        do_reset();
        core_enable = 3'b011;
        bus_idle(); bus_idle();
        push_exp(4'd1, 1'b1, 3'b011, 1'b0);
        write_fp(2, 4'd1, 1'b0, 32'hCAFE0000);
        write_fp(0, 4'd1, 1'b0, 32'h12345678);
        write_fp(1, 4'd1, 1'b0, 32'h12345679);
        bus_idle();
        wait_report(10, lat);
        core_enable = 3'b111;
        bus_idle(); bus_idle();
        push_exp(4'd2, 1'b0, 3'b000, 1'b0);
        for (int c = 0; c < 3; c++) write_fp(c, 4'd2, 1'b1, 32'h00000055);
        bus_idle();
        wait_report(10, lat);

`ifndef FPRINT_VOTE_TIMEOUT_EN
        // Full FIFO stalls the ninth upper write until the first compare pops
        do_reset();
        core_enable = 3'b111;
        bus_idle(); bus_idle();
        for (int k = 0; k < 8; k++) write_fp(0, 4'd1, 1'b0, 32'h0BAD0000 + 32'(k));
        drive_half(0, 1'b0, 1'b0, 4'd1, 16'h0008);
        #1 check("lower_never_stalls", fprint_waitrequest, 1'b0);
        drive_half(0, 1'b1, 1'b0, 4'd1, 16'h0BAD);
        #1 check("ninth_upper_stalls", fprint_waitrequest, 1'b1);
        bus_idle();
        write_fp(1, 4'd1, 1'b0, 32'h0BAD0000);
        write_fp(2, 4'd1, 1'b0, 32'h0BAD0000);
        drive_half(0, 1'b1, 1'b0, 4'd1, 16'h0BAD);
        #1 check("stall_before_compare", fprint_waitrequest, 1'b1);
        @(negedge clk);
        check("stall_during_compare", fprint_waitrequest, 1'b1);
        @(negedge clk);
        check("stall_released", fprint_waitrequest, 1'b0);
        bus_idle();
        repeat (3) @(negedge clk);
        check("no_report_on_match", status_write, 1'b0);
`endif

        // Malformed upper halves pulse protocol_error and push nothing
        do_reset();
        core_enable = 3'b111;
        bus_idle(); bus_idle();
        drive_half(0, 1'b1, 1'b0, 4'd3, 16'h1234);
        bus_idle();
        check("perr_orphan_upper", protocol_error, 1'b1);
        @(negedge clk);
        check("perr_single_cycle", protocol_error, 1'b0);
        drive_half(0, 1'b0, 1'b0, 4'd3, 16'h5678);
        drive_half(0, 1'b1, 1'b0, 4'd4, 16'h9ABC);
        check("perr_quiet_on_lower", protocol_error, 1'b0);
        bus_idle();
        check("perr_task_mismatch", protocol_error, 1'b1);
        @(negedge clk);
        check("perr_cleared", protocol_error, 1'b0);
        push_exp(4'd6, 1'b0, 3'b000, 1'b0);
        drive_half(0, 1'b0, 1'b0, 4'd6, 16'h1111);
        for (int c = 0; c < 3; c++) write_fp(c, 4'd6, 1'b1, 32'h600DF00D);
        bus_idle();
        wait_report(10, lat);

        // Reset during REPORT drops the report at once
        do_reset();
        core_enable = 3'b111;
        bus_idle(); bus_idle();
        write_fp(0, 4'd9, 1'b0, 32'h00000001);
        write_fp(1, 4'd9, 1'b0, 32'h00000001);
        write_fp(2, 4'd9, 1'b0, 32'h00000002);
        bus_idle();
        wait_write(10, lat);
        check("pre_reset_report", status_write, 1'b1);
        check("pre_reset_faulty", status_faulty, 3'b100);
        reset = 1'b0;
        #1 check("reset_drops_write", status_write, 1'b0);
        check("reset_clears_status", {status_task, status_mismatch, status_faulty}, '0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("report_dropped", status_write, 1'b0);

`ifdef FPRINT_VOTE_TIMEOUT_EN
        // Only core 0 writes: watchdog fires after 16 cycles and flushes
        do_reset();
        core_enable = 3'b111;
        bus_idle(); bus_idle();
        push_exp(4'd5, 1'b1, 3'b110, 1'b1);
        write_fp(0, 4'd5, 1'b0, 32'h5555AAAA);
        bus_idle();
        wait_report(40, lat);
        check("timeout_latency", lat, 16);
        push_exp(4'd8, 1'b0, 3'b000, 1'b0);
        for (int c = 0; c < 3; c++) write_fp(c, 4'd8, 1'b1, 32'h00000088);
        bus_idle();
        wait_report(10, lat);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
